// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding and the board baud constant.
// The transmit side reuses DEFAULT_CLKS_PER_BIT so both directions agree on the baud rate.
package uart_pkg;

  localparam int unsigned HW_CLK_HZ            = 12_000_000;
  localparam int unsigned BAUD_RATE            = 9600;
  localparam int unsigned DEFAULT_CLKS_PER_BIT = HW_CLK_HZ / BAUD_RATE;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_IDLE
  } rx_state_e;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 receiver core: input synchronizer, mid-bit sampling FSM and LSB-first shift register.
// Delivers framed bytes with a one-cycle rx_valid, or a one-cycle frame_err on a low stop bit.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic       hw_clk,
  input  logic       rst_n,
  input  logic       uartrx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned      CNT_W         = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rx_s;
  rx_state_e              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [2:0]             bit_idx_q, bit_idx_d;
  logic [7:0]             shift_q, shift_d;
  logic [7:0]             rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   frame_err_q, frame_err_d;

  assign sync_d = {sync_q[SYNC_STAGES-2:0], uartrx};
  assign rx_s   = sync_q[SYNC_STAGES-1];

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = RX_START;
      end
      RX_START: begin
        // Line must still be low at mid-start-bit, otherwise it was a glitch.
        if (cnt_q == CNT_HALF_LAST) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d     = '0;
          shift_d   = {rx_s, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        // Returning to IDLE at mid-stop-bit lets a back-to-back start bit be caught.
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
            state_d    = RX_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = RX_WAIT_IDLE;
          end
        end
      end
      RX_WAIT_IDLE: begin
        cnt_d = '0;
        if (rx_s) state_d = RX_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = RX_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge hw_clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '1;
      state_q     <= RX_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != RX_IDLE);

endmodule

// File: rtl/uart_rx_cmd.sv
// UART command receiver: wraps uart_rx_core and turns CMD_ON/CMD_OFF bytes into a
// persistent cmd_level, flagging any other byte with cmd_unknown alongside rx_valid.
module uart_rx_cmd
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter logic [7:0]  CMD_ON       = 8'h31,
  parameter logic [7:0]  CMD_OFF      = 8'h30
) (
  input  logic       hw_clk,
  input  logic       rst_n,
  input  logic       uartrx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy,
  output logic       cmd_level,
  output logic       cmd_unknown
);

  logic is_on, is_off;
  logic cmd_level_q, cmd_level_d;

  uart_rx_core #(
    .CLKS_PER_BIT (CLKS_PER_BIT),
    .SYNC_STAGES  (SYNC_STAGES)
  ) u_core (
    .hw_clk    (hw_clk),
    .rst_n     (rst_n),
    .uartrx    (uartrx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  assign is_on  = (rx_data == CMD_ON);
  assign is_off = (rx_data == CMD_OFF);

  // Only rx_valid qualifies the decode, so a byte with a framing error never reaches it.
  always_comb begin
    cmd_level_d = cmd_level_q;
    if (rx_valid && is_on)       cmd_level_d = 1'b1;
    else if (rx_valid && is_off) cmd_level_d = 1'b0;
  end

  always_ff @(posedge hw_clk or negedge rst_n) begin
    if (!rst_n) cmd_level_q <= 1'b0;
    else        cmd_level_q <= cmd_level_d;
  end

  assign cmd_level   = cmd_level_q;
  assign cmd_unknown = rx_valid && !is_on && !is_off;

endmodule

// File: tb/tb_uart_rx_cmd.sv
// Self-checking bench for uart_rx_cmd: a queue of expected frame events plus a command-level
// model is compared against the DUT every cycle; directed scenarios are followed by random frames.
module tb_uart_rx_cmd;

  localparam int CPB     = 160;
  localparam int HALF    = CPB / 2;
  localparam int SYNC    = 2;
  localparam int EXP_LAT = SYNC + HALF + 9 * CPB + 1;

  logic       hw_clk = 1'b0;
  logic       rst_n  = 1'b0;
  logic       uartrx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, busy, cmd_level, cmd_unknown;

  typedef struct {
    bit         err;
    logic [7:0] data;
    int         t_fall;
  } exp_t;

  exp_t       exp_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc   = 0;
  int         n_valid = 0, n_err = 0, n_unk = 0;
  logic [7:0] m_data  = 8'h00;
  logic       m_level = 1'b0;

  uart_rx_cmd #(
    .CLKS_PER_BIT (CPB),
    .SYNC_STAGES  (SYNC),
    .CMD_ON       (8'h31),
    .CMD_OFF      (8'h30)
  ) dut (
    .hw_clk      (hw_clk),
    .rst_n       (rst_n),
    .uartrx      (uartrx),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .frame_err   (frame_err),
    .busy        (busy),
    .cmd_level   (cmd_level),
    .cmd_unknown (cmd_unknown)
  );

  always #5 hw_clk = ~hw_clk;
  always @(posedge hw_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_lat(input int lat);
    n_cmp++;
    if (lat < EXP_LAT - 1 || lat > EXP_LAT + 1) begin
      n_bad++;
      $display("FAIL latency: got %0d cycles expected %0d +/-1", lat, EXP_LAT);
    end
  endtask

  function automatic bit is_unknown(input logic [7:0] d);
    return (d != 8'h31) && (d != 8'h30);
  endfunction

  // Expected behaviour: each well-framed byte yields one rx_valid with that byte, each
  // low stop bit yields one frame_err; cmd_level follows the last ON/OFF byte one cycle later.
  always @(negedge hw_clk) begin
    if (!rst_n) begin
      check("reset_outputs", {19'd0, rx_data, rx_valid, frame_err, busy, cmd_level, cmd_unknown}, 32'd0);
      m_data  = 8'h00;
      m_level = 1'b0;
      exp_q.delete();
    end else begin
      check("valid_err_exclusive", rx_valid & frame_err, 1'b0);
      check("cmd_level", cmd_level, m_level);
      if (rx_valid || frame_err) begin
        check("event_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check("event_kind_is_err", frame_err, e.err);
          check_lat(cyc - e.t_fall);
          if (rx_valid) begin
            n_valid++;
            check("rx_data", rx_data, e.data);
            check("cmd_unknown", cmd_unknown, is_unknown(e.data));
            m_data = e.data;
            if (e.data == 8'h31) m_level = 1'b1;
            else if (e.data == 8'h30) m_level = 1'b0;
          end else begin
            n_err++;
            check("rx_data_after_err", rx_data, m_data);
            check("cmd_unknown_on_err", cmd_unknown, 1'b0);
          end
        end
        if (cmd_unknown) n_unk++;
      end else begin
        check("rx_data_hold", rx_data, m_data);
        check("cmd_unknown_idle", cmd_unknown, 1'b0);
      end
    end
  end

  task automatic drive_bits(input logic [7:0] d, input int period, input logic stop_v, input int nbits);
    logic [9:0] fr;
    fr = {stop_v, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      uartrx = fr[i];
      repeat (period) @(negedge hw_clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input int period, input logic stop_v);
    exp_t e;
    e.err    = !stop_v;
    e.data   = d;
    e.t_fall = cyc;
    exp_q.push_back(e);
    drive_bits(d, period, stop_v, 10);
  endtask

  task automatic idle(input int n);
    uartrx = 1'b1;
    repeat (n) @(negedge hw_clk);
  endtask

  int v0, e0, u0;

  initial begin
    repeat (4) @(negedge hw_clk);
    #3 rst_n = 1'b1;
    @(negedge hw_clk);
    idle(20);

    // Single ON command.
    v0 = n_valid; u0 = n_unk;
    send_frame(8'h31, CPB, 1'b1);
    idle(2 * CPB);
    check("t1_valid_count", n_valid - v0, 1);
    check("t1_rx_data", rx_data, 8'h31);
    check("t1_cmd_level", cmd_level, 1'b1);
    check("t1_unknown_count", n_unk - u0, 0);
    check("t1_busy", busy, 1'b0);

    // OFF then unknown byte, no gap.
    v0 = n_valid; u0 = n_unk;
    send_frame(8'h30, CPB, 1'b1);
    send_frame(8'h41, CPB, 1'b1);
    idle(2 * CPB);
    check("t2_valid_count", n_valid - v0, 2);
    check("t2_rx_data", rx_data, 8'h41);
    check("t2_unknown_count", n_unk - u0, 1);
    check("t2_cmd_level", cmd_level, 1'b0);

    // Short low glitch on an idle line.
    v0 = n_valid; e0 = n_err;
    uartrx = 1'b0;
    repeat (10) @(negedge hw_clk);
    check("t3_busy_during_glitch", busy, 1'b1);
    repeat (HALF / 2 - 10) @(negedge hw_clk);
    idle(2 * CPB);
    check("t3_busy_after", busy, 1'b0);
    check("t3_no_events", (n_valid - v0) + (n_err - e0), 0);

    // Framing error, stuck-low line, then a good ON command.
    v0 = n_valid; e0 = n_err;
    send_frame(8'h55, CPB, 1'b0);
    repeat (5000) @(negedge hw_clk);
    check("t4_busy_while_low", busy, 1'b1);
    check("t4_err_count", n_err - e0, 1);
    check("t4_rx_data_kept", rx_data, 8'h41);
    check("t4_cmd_level_kept", cmd_level, 1'b0);
    idle(10);
    check("t4_busy_released", busy, 1'b0);
    send_frame(8'h31, CPB, 1'b1);
    idle(2 * CPB);
    check("t4_valid_count", n_valid - v0, 1);
    check("t4_cmd_level", cmd_level, 1'b1);

    // Reset in the middle of bit 4.
    drive_bits(8'hA5, CPB, 1'b1, 5);
    repeat (HALF) @(negedge hw_clk);
    #3 rst_n = 1'b0;
    uartrx = 1'b1;
    repeat (20) @(negedge hw_clk);
    check("t5_cmd_level_in_reset", cmd_level, 1'b0);
    check("t5_busy_in_reset", busy, 1'b0);
    #3 rst_n = 1'b1;
    @(negedge hw_clk);
    idle(CPB);
    v0 = n_valid;
    send_frame(8'h31, CPB, 1'b1);
    idle(2 * CPB);
    check("t5_valid_count", n_valid - v0, 1);
    check("t5_rx_data", rx_data, 8'h31);
    check("t5_cmd_level", cmd_level, 1'b1);

    // Baud tolerance at -2% and +2%.
    v0 = n_valid; e0 = n_err;
    send_frame(8'hC3, CPB - 3, 1'b1);
    idle(CPB);
    check("t6_fast_rx_data", rx_data, 8'hC3);
    send_frame(8'hC3, CPB + 3, 1'b1);
    idle(2 * CPB);
    check("t6_slow_rx_data", rx_data, 8'hC3);
    check("t6_valid_count", n_valid - v0, 2);
    check("t6_err_count", n_err - e0, 0);

    // Random frames: mixed commands, baud skew, gaps and occasional framing errors.
    for (int i = 0; i < 16; i++) begin
      logic [7:0] d;
      int         period;
      bit         bad;
      if ($urandom_range(0, 2) == 0) d = $urandom_range(0, 1) ? 8'h31 : 8'h30;
      else                           d = 8'($urandom);
      period = CPB - 3 + int'($urandom_range(0, 6));
      bad    = ($urandom_range(0, 5) == 0);
      send_frame(d, period, !bad);
      if (bad) begin
        repeat ($urandom_range(0, 300)) @(negedge hw_clk);
        idle(10 + int'($urandom_range(0, 20)));
      end else if ($urandom_range(0, 1) == 1) begin
        idle(int'($urandom_range(1, 40)));
      end
    end

    idle(4 * CPB);
    check("all_events_seen", exp_q.size(), 0);
    check("final_busy", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_cmd.md
Name: uart_rx_cmd

Overview:
- 8N1 UART receiver for the board's uartrx pin, clocked directly from the 12 MHz hw_clk. It is the receive-direction counterpart of the existing 9600-baud sensor-report transmitter.
- Samples each bit at mid-bit and delivers bytes with a one-cycle valid strobe.
- Decodes ASCII '1'/'0' commands into a persistent level output that drives a host-controlled LED/actuator.
- Sits between the uartrx pad and the top-level logic; exactly one instance per design.

Parameters:
- CLKS_PER_BIT, 1250: hw_clk cycles per UART bit (12 MHz / 9600). Legal range 16..65535.
- SYNC_STAGES, 2: flops in the uartrx input synchronizer (min 2).
- CMD_ON, 8'h31: byte that sets cmd_level (ASCII '1').
- CMD_OFF, 8'h30: byte that clears cmd_level (ASCII '0').

Ports:
- hw_clk  in  1  system clock, 12 MHz.
- rst_n  in  1  asynchronous, active-low reset.
- uartrx  in  1  serial input, asynchronous to hw_clk; idles high.
- rx_data  out  8  last correctly framed byte; held until the next valid byte.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- frame_err  out  1  one-cycle pulse when the stop bit is sampled low.
- busy  out  1  high from start-bit detect until the receiver returns to IDLE.
- cmd_level  out  1  persistent command state: 1 after CMD_ON, 0 after CMD_OFF.
- cmd_unknown  out  1  one-cycle pulse, coincident with rx_valid, for any byte other than CMD_ON or CMD_OFF.

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0; rx_data = 8'h00.
  - Synchronizer flops reset to 1 (idle line); FSM goes to IDLE; counters cleared.
  - Reset mid-frame abandons the frame with no rx_valid and no frame_err.
- Input path: uartrx passes through SYNC_STAGES flops to give rx_s. All decisions use rx_s only.
- Bit counter: width $clog2(CLKS_PER_BIT). HALF = CLKS_PER_BIT/2 (integer division).
- FSM states:
  - IDLE: on rx_s==0, go to START; clear counter; busy goes to 1 on the next edge.
  - START: count to HALF-1. At that sample, rx_s==1 is a glitch: go to IDLE with no pulses. rx_s==0 goes to DATA with counter and bit index cleared.
  - DATA: sample rx_s each time the counter reaches CLKS_PER_BIT-1, shifting LSB first into shift[7:0]. After bit index 7, go to STOP.
  - STOP: sample at CLKS_PER_BIT-1.
    - rx_s==1: rx_data<=shift, rx_valid pulses next cycle, go to IDLE.
    - rx_s==0: frame_err pulses, rx_data unchanged, go to WAIT_IDLE.
  - WAIT_IDLE: stay until rx_s==1 (a break or stuck-low line does not retrigger), then go to IDLE. busy stays 1 here.
- Latency: rx_valid rises SYNC_STAGES + HALF + 9*CLKS_PER_BIT + 1 cycles (±1) after the uartrx falling edge.
- Back-to-back frames: IDLE is re-entered at mid-stop-bit, so a start bit immediately after the stop bit is accepted with no gap needed.
- Command decode, registered in the same cycle as rx_valid:
  - rx_data==CMD_ON sets cmd_level=1.
  - rx_data==CMD_OFF sets cmd_level=0.
  - Any other byte leaves cmd_level unchanged and pulses cmd_unknown.
  - Repeating the same command is idempotent.
- A framed-error byte never affects cmd_level.
- rx_valid and frame_err are mutually exclusive; neither is ever high for more than one cycle.

Decomposition:
- Shared package/include (uart_pkg.vh): the rx FSM state encodings (IDLE, START, DATA, STOP, WAIT_IDLE) and the default CLKS_PER_BIT localparam (12_000_000/9600). The tx side reuses the same baud constant.
- One sub-module, uart_rx_core, containing the synchronizer, FSM and shift register, with outputs rx_data, rx_valid, frame_err and busy.
- uart_rx_cmd instantiates uart_rx_core and adds the command-decode register.

Test Plan:
- Send 8'h31 at 1250 clk/bit -> exactly one rx_valid with rx_data=8'h31; cmd_level 0->1; cmd_unknown=0; busy low after the stop bit.
- Send 8'h30, then 8'h41 back-to-back with zero idle gap -> cmd_level=0 after the first byte; second byte gives rx_data=8'h41, cmd_unknown pulses once, cmd_level stays 0.
- Low glitch of 400 cycles (< HALF=625) on an idle line -> no rx_valid, no frame_err; busy returns to 0 and the FSM returns to IDLE.
- Frame 8'h55 with the stop bit forced low, line held low for 5000 cycles, then released and 8'h31 sent -> one frame_err pulse; rx_data and cmd_level unchanged; no retrigger while low; the following 8'h31 is received correctly.
- Assert rst_n=0 during bit 4 of 8'hA5, release, then send 8'h31 -> all outputs 0 during reset; no rx_valid for the aborted frame; 8'h31 is received normally.
- Baud tolerance: send 8'hC3 with bit period 1250±2% (1225 and 1275 cycles) -> rx_data=8'hC3 in both cases; no frame_err.
